// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: operand-load bus and result stream for systolic_ctrl.
//   load_en/load_sel/load_addr/load_data : operand write port (A or B, index row*2+col)
//   res_valid/res_ready/res_data/res_last : valid/ready result stream, c00..c11 order
// slave  = controller side, master = host/consumer side.
interface systolic_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             load_en;
    logic             load_sel;
    logic [1:0]       load_addr;
    logic [WIDTH-1:0] load_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_last;

    modport slave (
        input  load_en, load_sel, load_addr, load_data, res_ready,
        output res_valid, res_data, res_last
    );

    modport master (
        output load_en, load_sel, load_addr, load_data, res_ready,
        input  res_valid, res_data, res_last
    );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 2x2 output-stationary systolic multiply.
// Stores A and B (2x2, signed WIDTH), clears the PE array, feeds skewed operands
// on the left/top edges for 4 cycles, captures the PE accumulators and streams
// the four results out over a valid/ready channel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : load port + result stream (see systolic_ctrl_if)
//   start               : begin a run with the stored A, B (IDLE only)
//   busy, done          : run in progress / one-cycle completion pulse
//   pe_clear            : accumulator clear strobe to the PEs
//   a_row0/1, b_col0/1  : operand feeds into the array edges
//   c_in                : PE accumulators {c11,c10,c01,c00}
module systolic_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_ctrl_if.slave     bus,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pe_clear,
    output logic [WIDTH-1:0]   a_row0,
    output logic [WIDTH-1:0]   a_row1,
    output logic [WIDTH-1:0]   b_col0,
    output logic [WIDTH-1:0]   b_col1,
    input  logic [4*WIDTH-1:0] c_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_k;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_a [4];
    logic [WIDTH-1:0] r_b [4];
    logic [WIDTH-1:0] r_c [4];

    logic             w_res_valid;
    logic             w_res_last;
    logic [WIDTH-1:0] w_res_data;

    assign bus.res_valid = w_res_valid;
    assign bus.res_last  = w_res_last;
    assign bus.res_data  = w_res_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        pe_clear     = 1'b0;
        a_row0       = '0;
        a_row1       = '0;
        b_col0       = '0;
        b_col1       = '0;
        w_res_valid  = 1'b0;
        w_res_last   = 1'b0;
        w_res_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy         = 1'b1;
                pe_clear     = 1'b1;
                w_next_state = S_FEED;
            end
            S_FEED: begin
                busy = 1'b1;
                // Row i / column j is skewed by i / j cycles: A[i][k-i], B[k-j][j].
                case (r_k)
                    2'd0: begin
                        a_row0 = r_a[0];
                        b_col0 = r_b[0];
                    end
                    2'd1: begin
                        a_row0 = r_a[1];
                        a_row1 = r_a[2];
                        b_col0 = r_b[2];
                        b_col1 = r_b[1];
                    end
                    2'd2: begin
                        a_row1 = r_a[3];
                        b_col1 = r_b[3];
                    end
                    default: begin
                    end
                endcase
                if (r_k == 2'd3) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy         = 1'b1;
                w_next_state = S_OUTPUT;
            end
            S_OUTPUT: begin
                busy        = 1'b1;
                w_res_valid = 1'b1;
                w_res_data  = r_c[r_idx];
                w_res_last  = (r_idx == 2'd3);
                if (bus.res_ready && (r_idx == 2'd3)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_idx <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && bus.load_en) begin
                if (bus.load_sel) begin
                    r_b[bus.load_addr] <= bus.load_data;
                end else begin
                    r_a[bus.load_addr] <= bus.load_data;
                end
            end

            // Counter wraps 3 -> 0 on the edge leaving FEED.
            if (r_state == S_FEED) begin
                r_k <= r_k + 2'd1;
            end else begin
                r_k <= '0;
            end

            if (r_state == S_DRAIN) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    r_c[i] <= c_in[i*WIDTH +: WIDTH];
                end
            end

            if (r_state == S_OUTPUT) begin
                if (bus.res_ready) begin
                    r_idx <= r_idx + 2'd1;
                end
            end else begin
                r_idx <= '0;
            end
        end
    end

endmodule
